// File: rtl/muldiv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 op codes, default widths,
// fixed latency and the unit's control types.
package muldiv_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_HART_ID_W  = 1;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int MULDIV_LATENCY = 33;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIN} md_state_e;

  // Control captured at accept; magnitudes are held separately.
  typedef struct packed {
    logic [2:0] op;
    logic       a_neg;
    logic       b_neg;
  } md_ctl_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input logic [2:0] op);
    return !(op == MULDIV_OP_MULHU || op == MULDIV_OP_DIVU || op == MULDIV_OP_REMU);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return op_a_signed(op) && (op != MULDIV_OP_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Final sign correction and result select for the iterative mul/div core.
// acc holds {hi, lo} = product, or {remainder, quotient} for divides.
module muldiv_unit_signfix
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [2:0]        op,
  input  logic              a_neg,
  input  logic              b_neg,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, a_orig;
  logic              b_zero;

  always_comb begin
    prod   = (a_neg ^ b_neg) ? -acc : acc;
    quo    = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem    = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    a_orig = a_neg ? -a_mag : a_mag;
    b_zero = (b_mag == '0);
    result = '0;
    case (op)
      MULDIV_OP_MUL:                                      result = prod[XLEN-1:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU:  result = prod[2*XLEN-1:XLEN];
      // Divide-by-zero overrides keep the RV32M-mandated values regardless of sign.
      MULDIV_OP_DIV, MULDIV_OP_DIVU:                      result = b_zero ? '1 : quo;
      default:                                            result = b_zero ? a_orig : rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on operand
// magnitudes, fixed 33-cycle latency, tagged result returned with a done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int HART_ID_W  = DEF_HART_ID_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e             state, state_nxt;
  logic                  accept, step_en, fin;
  logic [CNT_W-1:0]      cnt;
  md_ctl_t               ctl_q;
  logic [XLEN-1:0]       a_mag_q, b_mag_q;
  logic [2*XLEN-1:0]     acc, step_nxt;
  logic [HART_ID_W-1:0]  hart_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       fix_result;

  logic                  a_neg_in, b_neg_in;
  logic [XLEN-1:0]       a_mag_in, b_mag_in;

  always_comb begin
    a_neg_in = op_a_signed(muldiv_op) && muldiv_a[XLEN-1];
    b_neg_in = op_b_signed(muldiv_op) && muldiv_b[XLEN-1];
    a_mag_in = a_neg_in ? -muldiv_a : muldiv_a;
    b_mag_in = b_neg_in ? -muldiv_b : muldiv_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step_en   = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: if (muldiv_start) begin
        accept    = 1'b1;
        state_nxt = ST_CALC;
      end
      ST_CALC: begin
        step_en = 1'b1;
        if (cnt == CNT_W'(XLEN-1)) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        fin       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Multiply: acc = {partial_hi, multiplier}, shifting right as bits retire.
  // Divide:   acc = {remainder, dividend->quotient}, shifting left (restoring).
  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} +
                {1'b0, (acc[0] ? a_mag_q : {XLEN{1'b0}})};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_mag_q});
    div_diff  = div_shift[XLEN-1:0] - b_mag_q;
    if (op_is_div(ctl_q.op))
      step_nxt = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    else
      step_nxt = {mul_sum, acc[XLEN-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt                 <= '0;
      ctl_q               <= '0;
      a_mag_q             <= '0;
      b_mag_q             <= '0;
      acc                 <= '0;
      hart_q              <= '0;
      rd_q                <= '0;
      muldiv_busy         <= 1'b0;
      muldiv_done         <= 1'b0;
      muldiv_result       <= '0;
      muldiv_done_hart_id <= '0;
      muldiv_done_rd      <= '0;
    end else begin
      muldiv_done <= 1'b0;
      if (accept) begin
        ctl_q       <= {muldiv_op, a_neg_in, b_neg_in};
        a_mag_q     <= a_mag_in;
        b_mag_q     <= b_mag_in;
        acc         <= {{XLEN{1'b0}}, (op_is_div(muldiv_op) ? a_mag_in : b_mag_in)};
        hart_q      <= muldiv_hart_id;
        rd_q        <= muldiv_rd;
        cnt         <= '0;
        muldiv_busy <= 1'b1;
      end
      if (step_en) begin
        acc <= step_nxt;
        cnt <= cnt + 1'b1;
      end
      if (fin) begin
        muldiv_result       <= fix_result;
        muldiv_done         <= 1'b1;
        muldiv_busy         <= 1'b0;
        muldiv_done_hart_id <= hart_q;
        muldiv_done_rd      <= rd_q;
      end
    end
  end

  muldiv_unit_signfix #(.XLEN(XLEN)) u_signfix (
    .op     (ctl_q.op),
    .a_neg  (ctl_q.a_neg),
    .b_neg  (ctl_q.b_neg),
    .a_mag  (a_mag_q),
    .b_mag  (b_mag_q),
    .acc    (acc),
    .result (fix_result)
  );

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit that sits directly downstream of cpu_top's muldiv request port and returns results through its done port.
It accepts one operation at a time, tagged with hart id and destination register, and computes it over a fixed number of cycles.
It returns the result with the same tag so the core can write back to the correct hart's register file.
Latency is fixed for all ops and operands, so the core's scheduling is operand-independent.

Parameters:
XLEN, 32, operand/result width (from defines.vh `XLEN)
HART_ID_W, 1, hart tag width (from defines.vh `HART_ID_W)
REG_ADDR_W, 5, destination register tag width (from defines.vh `REG_ADDR_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
muldiv_start  input  1  request valid; accepted only when busy=0
muldiv_op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
muldiv_a  input  XLEN  rs1 operand
muldiv_b  input  XLEN  rs2 operand
muldiv_hart_id  input  HART_ID_W  issuing hart tag
muldiv_rd  input  REG_ADDR_W  destination register tag
muldiv_busy  output  1  operation in flight; new starts ignored
muldiv_done  output  1  one-cycle pulse; result and tags valid
muldiv_result  output  XLEN  result; held until next done
muldiv_done_hart_id  output  HART_ID_W  tag captured at accept
muldiv_done_rd  output  REG_ADDR_W  tag captured at accept

Behaviour:
- Reset (async, rst_n=0): busy=0, done=0, result=0, done_hart_id=0, done_rd=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, CALC, FIN.
- IDLE: on edge E with start=1, latch op, operand magnitudes, sign flags, hart_id and rd; go to CALC with counter=0; busy=1 after E.
- CALC: one radix-2 step per edge for edges E+1..E+32 (counter 0..31); go to FIN after counter=31.
  - Multiply: unsigned shift-add of magnitudes into a 64-bit product.
  - Divide: restoring shift-subtract of magnitudes.
- FIN (edge E+33): apply sign fix-up and select output; register result/tags; done=1 and busy=0 for exactly one cycle; return to IDLE.
- Latency: done is high in the cycle after edge E+33; busy is high for 33 cycles.
- A start during the done cycle is accepted at that edge (back-to-back issue allowed).
- start while busy=1 is ignored; latched operands and tags are unaffected; no queueing.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU/DIVU/REMU treat both as unsigned.
- Result selection: MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Product negation: negate the 64-bit product when exactly one signed operand is negative.
- Quotient sign: negative when operand signs differ. Remainder sign: follows the dividend.
- Divide by zero (b=0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return a. Latency is unchanged.
- Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- Reset mid-operation: busy/done drop immediately; the aborted op never produces done; the next op after reset release is computed correctly.
- done_hart_id/done_rd always reflect the accepted request, never live inputs.

Decomposition:
- Shared defines/package: MULDIV_OP_* funct3 constants, `XLEN, `HART_ID_W, `REG_ADDR_W, MULDIV_LATENCY=33. cpu_top uses the same op constants.
- Single module; no sub-module required.
- Optional helper: muldiv_signfix, a combinational negate/select block, if FIN logic grows.

Test Plan:
- MUL a=7 b=6 hart=1 rd=5 -> done exactly 33 edges after accept; result=42, done_hart_id=1, done_rd=5; busy high 33 cycles; done high 1 cycle.
- Multiply variants:
  - MUL -3*5 -> 0xFFFFFFF1
  - MULH 0x80000000*0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
- Divide variants:
  - DIV -7/2 -> 0xFFFFFFFD
  - REM -7,2 -> 0xFFFFFFFF
  - DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC
  - REMU 0xFFFFFFF9,2 -> 1
- Corner cases:
  - DIV 5/0 -> 0xFFFFFFFF
  - REM 5,0 -> 5
  - REMU 0xFFFFFFF9,0 -> 0xFFFFFFF9
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM same operands -> 0
- Issue rules:
  - Start MUL 3*4 while busy with MUL 7*6 -> ignored; result 42, tags unchanged.
  - Start DIVU 100/7 in the done cycle -> accepted; result 14 after 33 more edges.
- Reset: assert rst_n=0 at iteration 10 of DIV -> busy=0, done=0 immediately; no stale done after release; following REM 100,7 -> 2.
